// File: rtl/pe_dot_engine.sv
// pe_dot_engine: signed integer dot product of a streamed operand vector A
// against weights held in a local weight RAM (peram).
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   we, waddr, wdata      peram write port (honoured only while idle)
//   start, len            job start pulse and vector length (0..2**L_RAM_SIZE)
//   ain, ain_valid/ready  streamed operand A, valid/ready handshake
//   dout, dvalid/dready   dot-product result, valid/ready handshake
//   busy                  high whenever the engine is not idle
//   ovf                   sticky overflow (wrap or saturation) for the current job
module pe_dot_engine #(
   parameter int unsigned DW         = 16,
   parameter int unsigned L_RAM_SIZE = 4,
   parameter int unsigned ACC_W      = 40,
   parameter int unsigned MUL_LAT    = 2,
   parameter int unsigned SAT        = 0
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  we,
   input  logic [L_RAM_SIZE-1:0] waddr,
   input  logic [DW-1:0]         wdata,
   input  logic                  start,
   input  logic [L_RAM_SIZE:0]   len,
   input  logic [DW-1:0]         ain,
   input  logic                  ain_valid,
   output logic                  ain_ready,
   output logic [ACC_W-1:0]      dout,
   output logic                  dvalid,
   input  logic                  dready,
   output logic                  busy,
   output logic                  ovf
);

   localparam int unsigned DEPTH = 2**L_RAM_SIZE;
   localparam int unsigned PW    = 2*DW;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   logic [DW-1:0] peram [DEPTH];

   state_t                  state_q, state_d;
   logic [L_RAM_SIZE:0]     len_q, len_d;
   logic [L_RAM_SIZE:0]     cnt_q, cnt_d;
   logic signed [DW-1:0]    a_q, a_d;
   logic signed [DW-1:0]    w_q, w_d;
   logic                    s0v_q, s0v_d;
   logic signed [PW-1:0]    prod_q [MUL_LAT];
   logic signed [PW-1:0]    prod_d [MUL_LAT];
   logic [MUL_LAT-1:0]      pv_q, pv_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    ovf_q, ovf_d;
   logic [ACC_W-1:0]        dout_q, dout_d;
   logic                    dvalid_q, dvalid_d;
   logic                    ain_ready_q, ain_ready_d;
   logic                    busy_q, busy_d;

   logic                    accept;
   logic signed [ACC_W-1:0] addend;
   logic signed [ACC_W-1:0] sum;
   logic                    add_ovf;

   // ain_ready_q is only ever high in RUN, so it also gates ain_valid outside RUN.
   assign accept  = ain_valid & ain_ready_q;
   assign addend  = ACC_W'(prod_q[MUL_LAT-1]);
   assign sum     = acc_q + addend;
   // Signed overflow: both operands share a sign that the result does not.
   assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

   // Weight RAM: no reset; writes only while idle so a running job sees stable weights.
   always_ff @(posedge aclk) begin
      if (we && !busy_q) begin
         peram[waddr] <= wdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      w_d         = w_q;
      s0v_d       = accept;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      dout_d      = dout_q;
      dvalid_d    = dvalid_q;
      ain_ready_d = ain_ready_q;
      busy_d      = busy_q;

      // Stage 0: registered weight read paired with the accepted operand.
      if (accept) begin
         a_d = ain;
         w_d = peram[cnt_q[L_RAM_SIZE-1:0]];
      end

      // Stages 1..MUL_LAT: product then delay registers.
      prod_d[0] = PW'(a_q) * PW'(w_q);
      pv_d[0]   = s0v_q;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
         prod_d[k] = prod_q[k-1];
         pv_d[k]   = pv_q[k-1];
      end

      // Final stage: accumulate, wrapping or clamping toward the sign of the old value.
      if (pv_q[MUL_LAT-1]) begin
         acc_d = sum;
         if (add_ovf) begin
            ovf_d = 1'b1;
            if (SAT != 0) begin
               acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d  = len;
               cnt_d  = '0;
               acc_d  = '0;
               ovf_d  = 1'b0;
               busy_d = 1'b1;
               if (len == '0) begin
                  dout_d   = '0;
                  dvalid_d = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  ain_ready_d = 1'b1;
                  state_d     = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (accept) begin
               cnt_d = cnt_q + (L_RAM_SIZE+1)'(1);
               if (cnt_q == len_q - (L_RAM_SIZE+1)'(1)) begin
                  ain_ready_d = 1'b0;
                  state_d     = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!s0v_q && (pv_q == '0)) begin
               dout_d   = acc_q;
               dvalid_d = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (dready) begin
               dvalid_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         w_q         <= '0;
         s0v_q       <= 1'b0;
         for (int unsigned k = 0; k < MUL_LAT; k++) begin
            prod_q[k] <= '0;
         end
         pv_q        <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         dout_q      <= '0;
         dvalid_q    <= 1'b0;
         ain_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         w_q         <= w_d;
         s0v_q       <= s0v_d;
         for (int unsigned k = 0; k < MUL_LAT; k++) begin
            prod_q[k] <= prod_d[k];
         end
         pv_q        <= pv_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         dout_q      <= dout_d;
         dvalid_q    <= dvalid_d;
         ain_ready_q <= ain_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign ain_ready = ain_ready_q;
   assign dout      = dout_q;
   assign dvalid    = dvalid_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_dot_engine.sv
// tb_pe_dot_engine: directed bench for pe_dot_engine. Three instances share
// all inputs: default parameters (ACC_W=40, wrap), ACC_W=32 saturating and
// ACC_W=32 wrapping. Expected results are computed from a bench-side copy of
// the weight RAM when each job starts and checked when the result is taken.
module tb_pe_dot_engine;

   localparam int unsigned DW      = 16;
   localparam int unsigned LR      = 4;
   localparam int unsigned MUL_LAT = 2;
   localparam longint SMAX32 = 64'sd2147483647;
   localparam longint SMIN32 = -64'sd2147483648;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b1;
   logic          we = 1'b0;
   logic [LR-1:0] waddr = '0;
   logic [DW-1:0] wdata = '0;
   logic          start = 1'b0;
   logic [LR:0]   len = '0;
   logic [DW-1:0] ain = '0;
   logic          ain_valid = 1'b0;
   logic          dready = 1'b0;

   logic          ain_ready_def, dvalid_def, busy_def, ovf_def;
   logic [39:0]   dout_def;
   logic          ain_ready_sat, dvalid_sat, busy_sat, ovf_sat;
   logic [31:0]   dout_sat;
   logic          ain_ready_wrap, dvalid_wrap, busy_wrap, ovf_wrap;
   logic [31:0]   dout_wrap;

   pe_dot_engine #(.DW(DW), .L_RAM_SIZE(LR), .ACC_W(40), .MUL_LAT(MUL_LAT), .SAT(0)) u_def (
      .aclk(aclk), .aresetn(aresetn), .we(we), .waddr(waddr), .wdata(wdata),
      .start(start), .len(len), .ain(ain), .ain_valid(ain_valid), .ain_ready(ain_ready_def),
      .dout(dout_def), .dvalid(dvalid_def), .dready(dready), .busy(busy_def), .ovf(ovf_def));

   pe_dot_engine #(.DW(DW), .L_RAM_SIZE(LR), .ACC_W(32), .MUL_LAT(MUL_LAT), .SAT(1)) u_sat (
      .aclk(aclk), .aresetn(aresetn), .we(we), .waddr(waddr), .wdata(wdata),
      .start(start), .len(len), .ain(ain), .ain_valid(ain_valid), .ain_ready(ain_ready_sat),
      .dout(dout_sat), .dvalid(dvalid_sat), .dready(dready), .busy(busy_sat), .ovf(ovf_sat));

   pe_dot_engine #(.DW(DW), .L_RAM_SIZE(LR), .ACC_W(32), .MUL_LAT(MUL_LAT), .SAT(0)) u_wrap (
      .aclk(aclk), .aresetn(aresetn), .we(we), .waddr(waddr), .wdata(wdata),
      .start(start), .len(len), .ain(ain), .ain_valid(ain_valid), .ain_ready(ain_ready_wrap),
      .dout(dout_wrap), .dvalid(dvalid_wrap), .dready(dready), .busy(busy_wrap), .ovf(ovf_wrap));

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic [39:0] d_def;
      logic [31:0] d_sat;
      logic [31:0] d_wrap;
      logic        o_def;
      logic        o_sat;
      logic        o_wrap;
   } exp_t;

   exp_t    sb[$];
   shortint tb_mem [16];
   shortint avec [16];
   int      checks = 0;
   int      errors = 0;
   int      last_acc = 0;
   int      exp_dv = 0;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic longint wrapn(input longint v, input int n);
      return (v <<< (64 - n)) >>> (64 - n);
   endfunction

   function automatic exp_t model(input int n);
      exp_t   e;
      longint p, t;
      longint a40 = 0;
      longint a32 = 0;
      longint as32 = 0;
      e.o_def = 1'b0; e.o_sat = 1'b0; e.o_wrap = 1'b0;
      for (int i = 0; i < n; i++) begin
         p = longint'(tb_mem[i]) * longint'(avec[i]);
         t = a40 + p;
         if (wrapn(t, 40) != t) e.o_def = 1'b1;
         a40 = wrapn(t, 40);
         t = a32 + p;
         if (wrapn(t, 32) != t) e.o_wrap = 1'b1;
         a32 = wrapn(t, 32);
         t = as32 + p;
         if (t > SMAX32) begin
            as32 = SMAX32; e.o_sat = 1'b1;
         end else if (t < SMIN32) begin
            as32 = SMIN32; e.o_sat = 1'b1;
         end else begin
            as32 = t;
         end
      end
      e.d_def  = a40[39:0];
      e.d_sat  = as32[31:0];
      e.d_wrap = a32[31:0];
      return e;
   endfunction

   task automatic wr(input int addr, input shortint data);
      we = 1'b1;
      waddr = addr[LR-1:0];
      wdata = data;
      tb_mem[addr] = data;
      tick();
      we = 1'b0;
   endtask

   task automatic do_start(input int n, input bit push);
      start = 1'b1;
      len = n[LR:0];
      if (push) sb.push_back(model(n));
      tick();
      start = 1'b0;
      exp_dv = cyc;
   endtask

   task automatic stream(input int n, input bit gappy);
      int idx = 0;
      int budget = 200;
      bit ph = 1'b1;
      while (idx < n && budget > 0) begin
         ain_valid = gappy ? ph : 1'b1;
         ph = ~ph;
         ain = avec[idx];
         if (ain_valid && ain_ready_def) begin
            last_acc = cyc + 1;
            idx++;
         end
         tick();
         budget--;
      end
      ain_valid = 1'b0;
      chk("stream_accepts", idx, n);
      exp_dv = last_acc + MUL_LAT + 2;
   endtask

   task automatic collect(input int hold, input bit start_on_hs);
      exp_t e;
      int budget = 50;
      e.d_def = '0; e.d_sat = '0; e.d_wrap = '0;
      e.o_def = 1'b0; e.o_sat = 1'b0; e.o_wrap = 1'b0;
      while (!dvalid_def && budget > 0) begin
         tick();
         budget--;
      end
      chk("dvalid_seen", dvalid_def, 1);
      chk("dvalid_latency", cyc, exp_dv);
      chk("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) e = sb.pop_front();
      for (int k = 0; k < hold; k++) begin
         chk("hold_dvalid", dvalid_def, 1);
         chk("hold_dout", dout_def, e.d_def);
         tick();
      end
      dready = 1'b1;
      if (start_on_hs) begin
         start = 1'b1;
         len = 1;
      end
      chk("dout_def", dout_def, e.d_def);
      chk("dout_sat", dout_sat, e.d_sat);
      chk("dout_wrap", dout_wrap, e.d_wrap);
      chk("ovf_def", ovf_def, e.o_def);
      chk("ovf_sat", ovf_sat, e.o_sat);
      chk("ovf_wrap", ovf_wrap, e.o_wrap);
      chk("dvalid_others", {dvalid_sat, dvalid_wrap}, 2'b11);
      tick();
      dready = 1'b0;
      start = 1'b0;
      chk("busy_after_hs", {busy_def, busy_sat, busy_wrap}, 3'b000);
      chk("dvalid_after_hs", dvalid_def, 0);
      tick();
      chk("idle_stays", busy_def, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {dout_def, dvalid_def, ain_ready_def, busy_def, ovf_def}, '0);
      chk(tag, {dout_sat, dvalid_sat, ain_ready_sat, busy_sat, ovf_sat}, '0);
      chk(tag, {dout_wrap, dvalid_wrap, ain_ready_wrap, busy_wrap, ovf_wrap}, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 aresetn = 1'b0;
      #1 chk_all_zero("reset_outputs");
      repeat (2) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      tick();
      chk_all_zero("after_release");

      // Basic job, back-to-back stream
      wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
      avec[0] = 5; avec[1] = 6; avec[2] = 7; avec[3] = 8;
      do_start(4, 1);
      stream(4, 0);
      chk("ain_ready_drain", ain_ready_def, 0);
      collect(0, 0);

      // Bubbled stream, consumer stalls, start on handshake ignored
      do_start(4, 1);
      stream(4, 1);
      collect(5, 1);

      // Signed product; write and start in the same idle cycle
      we = 1'b1; waddr = 0; wdata = 16'hFFFD; tb_mem[0] = -3;
      avec[0] = 7;
      do_start(1, 1);
      we = 1'b0;
      stream(1, 0);
      collect(0, 0);

      // len = 0
      do_start(0, 1);
      chk("len0_no_ready", ain_ready_def, 0);
      collect(0, 0);

      // Start while busy ignored, write while busy dropped, rerun unchanged
      wr(0, 1);
      avec[0] = 5; avec[1] = 6; avec[2] = 7; avec[3] = 8;
      do_start(4, 1);
      we = 1'b1; waddr = 0; wdata = 16'd99;
      start = 1'b1; len = 1;
      tick();
      we = 1'b0; start = 1'b0;
      stream(4, 0);
      start = 1'b1; len = 2;
      tick();
      start = 1'b0;
      collect(0, 0);
      do_start(4, 1);
      stream(4, 0);
      collect(0, 0);

      // Full-depth job driving saturation / wrap
      for (int i = 0; i < 16; i++) begin
         wr(i, -16'sd32768);
         avec[i] = -16'sd32768;
      end
      do_start(16, 1);
      stream(16, 0);
      collect(0, 0);

      // Reset mid-job, then a fresh job on intact weights
      wr(0, 1234); wr(1, -567);
      avec[0] = 5; avec[1] = 6; avec[2] = 7; avec[3] = 8;
      do_start(4, 0);
      stream(2, 0);
      #2 aresetn = 1'b0;
      #1 chk_all_zero("reset_midjob");
      @(negedge aclk) aresetn = 1'b1;
      tick();
      avec[0] = 3; avec[1] = -4;
      do_start(2, 1);
      stream(2, 0);
      collect(0, 0);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_dot_engine.md
Name: pe_dot_engine

Overview:
Parametrised successor to the single-lane processing element. It holds a local weight RAM (peram) and, on a start command, computes a signed integer dot product over a programmable vector length. Operand A is streamed in with a valid/ready handshake and weights are read from peram, so no vendor multiply-add core is needed. The result is held under a valid/ready output handshake, and the block sits between the AXI-facing controller and the result collector.

Parameters:
DW, 16, operand width (A and peram words), signed two's complement
L_RAM_SIZE, 4, peram address width; depth = 2**L_RAM_SIZE
ACC_W, 40, accumulator and dout width (must be >= 2*DW)
MUL_LAT, 2, pipeline register stages after the product (>= 1)
SAT, 0, 0 = accumulator wraps modulo 2**ACC_W; 1 = saturates to signed ACC_W limits

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
we  in  1  peram write enable
waddr  in  L_RAM_SIZE  peram write address
wdata  in  DW  peram write data
start  in  1  begin a dot product (single-cycle pulse)
len  in  L_RAM_SIZE+1  vector length 0..2**L_RAM_SIZE, sampled on accepted start
ain  in  DW  streamed operand A
ain_valid  in  1  ain is valid
ain_ready  out  1  block accepts ain this cycle
dout  out  ACC_W  dot-product result
dvalid  out  1  dout valid
dready  in  1  consumer accepts dout
busy  out  1  high in any state except IDLE
ovf  out  1  sticky: saturation or wrap occurred in the current job

Behaviour:
- Reset (asynchronous assert, synchronous release on aclk): state=IDLE, dout=0, dvalid=0, ain_ready=0, busy=0, ovf=0, and the element counter and accumulator are cleared. peram contents are not reset. Reset asserted mid-job abandons the job and discards in-flight pipeline data.
- FSM states:
  - IDLE: start=1 latches len, clears the accumulator and ovf, then goes to RUN. If len=0 it goes to DONE instead, with dout=0.
  - RUN: ain_ready=1. Each cycle with ain_valid & ain_ready is one accepted element; element i pairs with peram[i], i = 0..len-1. Bubbles are allowed. After the len-th accept, go to DRAIN; ain_ready drops in the following cycle.
  - DRAIN: wait until the pipeline is empty, then load dout with the final accumulator and go to DONE.
  - DONE: dvalid=1 and dout is held stable. When dvalid & dready, go to IDLE with dvalid=0.
- Pipeline:
  - Stage 0: peram registered read at index i, with ain delayed by one register.
  - Stages 1..MUL_LAT: signed product, 2*DW bits.
  - Final stage: sign-extended add into the accumulator.
  - Latency: last element accepted at cycle t gives dvalid=1 at cycle t+MUL_LAT+3.
- Arithmetic:
  - SAT=0: modulo-2**ACC_W wrap. ovf is set if any single add overflowed signed ACC_W.
  - SAT=1: clamp to +2**(ACC_W-1)-1 or -2**(ACC_W-1), and set ovf. Later adds continue from the clamped value.
- peram writes: accepted only when busy=0. Writes with busy=1 are dropped with no other effect. A write and a start in the same IDLE cycle: the write takes effect first, so the job sees the new word.
- start while busy=1 is ignored. start in the same cycle as the DONE handshake is ignored; the consumer must re-issue it once in IDLE.
- ain_valid outside RUN has no effect.
- ovf is valid together with dvalid and holds until the next accepted start.
- len > 2**L_RAM_SIZE cannot be encoded. len = 2**L_RAM_SIZE uses the full RAM.

Test Plan:
- Program peram[0..3]={1,2,3,4}, start with len=4, stream ain={5,6,7,8} back-to-back, dready=1 -> dout=70, dvalid exactly MUL_LAT+3 cycles after the 4th accept, ovf=0, busy falls the cycle after the handshake.
- Same job with ain_valid toggling 1,0,1,0 and dready held low for 5 cycles after dvalid -> dout=70 held stable with dvalid=1 for all 5 cycles; single-cycle handshake then IDLE.
- Signed: peram[0]=-3, ain=7, len=1 -> dout = -21 sign-extended to ACC_W.
- Saturation: DW=16, ACC_W=32, SAT=1, all 16 entries = -32768, ain all -32768 -> dout=0x7FFFFFFF, ovf=1. The same job with SAT=0 gives dout=0x00000000 (16*2**30 wraps), ovf=1.
- Boundary: start with len=0 -> dvalid the cycle after start, dout=0, no ain accepted. A second start while busy is ignored. A we to peram[0] during RUN is dropped (a rerun returns the original result).
- Assert aresetn low during RUN after 2 accepts -> all outputs 0 immediately. After release, a fresh job with len=2 returns the correct dout, and the peram contents are intact.
